// File: rtl/dbc_port_change_gen.sv
// DbC port status change generator: debounced connect, sticky change bits, coalesced event request.
// Optional build macro DBC_PLS_LPM_FILTER_EN suppresses PLC on U0<->U1 and U0<->U2 hops.
module dbc_port_change_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PLS_W           = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             DCE,
  input  logic             conn_raw,
  input  logic [PLS_W-1:0] pls_in,
  input  logic             port_rst_busy,
  input  logic             cfg_err,
  input  logic             w1c_valid,
  input  logic [3:0]       w1c_mask,
  input  logic             evt_ack,
  output logic             CCS,
  output logic [PLS_W-1:0] PLS,
  output logic             CSC,
  output logic             PLC,
  output logic             PRC,
  output logic             CEC,
  output logic             PED,
  output logic             evt_req
);

  typedef enum logic {DbStable, DbCount} db_state_e;
  typedef enum logic [1:0] {EvIdle, EvReq, EvWaitClr} ev_state_e;

  localparam logic [7:0] DbLimit = 8'(DEBOUNCE_CYCLES);

  db_state_e        db_state_q, db_state_d;
  ev_state_e        ev_state_q, ev_state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ccs_q, ccs_d;
  logic [PLS_W-1:0] pls_q;
  logic             csc_q, csc_d, plc_q, plc_d, prc_q, prc_d, cec_q, cec_d;
  logic             ped_q, ped_d;
  logic             busy_q;

  logic             ccs_toggle, ccs_fall;
  logic             lpm_hop, plc_set, busy_fall, busy_rise, any_chg;
  logic [3:0]       w1c;

  // Debounce: CCS flips once conn_raw has disagreed for DEBOUNCE_CYCLES consecutive samples
  always_comb begin
    db_state_d = db_state_q;
    cnt_d      = cnt_q;
    ccs_toggle = 1'b0;
    unique case (db_state_q)
      DbStable: begin
        if (conn_raw != ccs_q) begin
          if (DbLimit == 8'd1) begin
            ccs_toggle = 1'b1;
          end else begin
            db_state_d = DbCount;
            cnt_d      = 8'd1;
          end
        end
      end
      DbCount: begin
        if (conn_raw == ccs_q) begin
          db_state_d = DbStable;
          cnt_d      = 8'd0;
        end else if (cnt_q + 8'd1 == DbLimit) begin
          ccs_toggle = 1'b1;
          db_state_d = DbStable;
          cnt_d      = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

`ifdef DBC_PLS_LPM_FILTER_EN
  localparam logic [PLS_W-1:0] PlsU0 = PLS_W'(0);
  localparam logic [PLS_W-1:0] PlsU1 = PLS_W'(1);
  localparam logic [PLS_W-1:0] PlsU2 = PLS_W'(2);
  assign lpm_hop = ((pls_q == PlsU0) && ((pls_in == PlsU1) || (pls_in == PlsU2))) ||
                   ((pls_in == PlsU0) && ((pls_q == PlsU1) || (pls_q == PlsU2)));
`else
  assign lpm_hop = 1'b0;
`endif

  assign ccs_d     = ccs_q ^ ccs_toggle;
  assign ccs_fall  = ccs_toggle & ccs_q;
  assign plc_set   = (pls_in != pls_q) & ccs_q & ~lpm_hop;
  assign busy_fall = busy_q & ~port_rst_busy;
  assign busy_rise = ~busy_q & port_rst_busy;
  assign w1c       = {4{w1c_valid}} & w1c_mask;

  // A set on the same edge as a software clear wins
  assign csc_d = ccs_toggle | (csc_q & ~w1c[0]);
  assign plc_d = plc_set    | (plc_q & ~w1c[1]);
  assign prc_d = busy_fall  | (prc_q & ~w1c[2]);
  assign cec_d = cfg_err    | (cec_q & ~w1c[3]);

  always_comb begin
    ped_d = ped_q;
    if (ccs_fall || cfg_err || busy_rise) begin
      ped_d = 1'b0;
    end else if (busy_fall && ccs_q) begin
      ped_d = 1'b1;
    end
  end

  assign any_chg = csc_q | plc_q | prc_q | cec_q;

  always_comb begin
    ev_state_d = ev_state_q;
    unique case (ev_state_q)
      EvIdle:    if (any_chg) ev_state_d = EvReq;
      EvReq:     if (evt_ack) ev_state_d = EvWaitClr;
      EvWaitClr: if (!any_chg) ev_state_d = EvIdle;
      default:   ev_state_d = EvIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_state_q <= DbStable;
      ev_state_q <= EvIdle;
      cnt_q      <= 8'd0;
      ccs_q      <= 1'b0;
      pls_q      <= '0;
      csc_q      <= 1'b0;
      plc_q      <= 1'b0;
      prc_q      <= 1'b0;
      cec_q      <= 1'b0;
      ped_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else if (!DCE) begin
      db_state_q <= DbStable;
      ev_state_q <= EvIdle;
      cnt_q      <= 8'd0;
      ccs_q      <= 1'b0;
      pls_q      <= '0;
      csc_q      <= 1'b0;
      plc_q      <= 1'b0;
      prc_q      <= 1'b0;
      cec_q      <= 1'b0;
      ped_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      db_state_q <= db_state_d;
      ev_state_q <= ev_state_d;
      cnt_q      <= cnt_d;
      ccs_q      <= ccs_d;
      pls_q      <= pls_in;
      csc_q      <= csc_d;
      plc_q      <= plc_d;
      prc_q      <= prc_d;
      cec_q      <= cec_d;
      ped_q      <= ped_d;
      busy_q     <= port_rst_busy;
    end
  end

  assign CCS     = ccs_q;
  assign PLS     = pls_q;
  assign CSC     = csc_q;
  assign PLC     = plc_q;
  assign PRC     = prc_q;
  assign CEC     = cec_q;
  assign PED     = ped_q;
  assign evt_req = (ev_state_q == EvReq);

endmodule

// File: doc/dbc_port_change_gen.md
Name: dbc_port_change_gen

Overview:
- Upstream feeder for the DbC port state machine.
- Turns raw PHY/link indications into the sticky port status change bits CSC, PLC, PRC, CEC, plus PED, CCS and registered PLS.
- Debounces connect, detects link-state and reset-completion edges, and supports software write-1-to-clear of the change bits.
- Raises one coalesced port-status-change event request toward the event ring, using a req/ack handshake.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles conn_raw must differ from CCS before CCS flips (legal range 1..255).
PLS_W, 4, width of the port link state field.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
DCE  input  1  DbC enable; 0 = block held cleared.
conn_raw  input  1  raw connect detect from PHY.
pls_in  input  PLS_W  link state from PHY.
port_rst_busy  input  1  port reset in progress.
cfg_err  input  1  one-cycle configuration error pulse.
w1c_valid  input  1  software clear strobe.
w1c_mask  input  4  bits to clear: [0]=CSC, [1]=PLC, [2]=PRC, [3]=CEC.
evt_ack  input  1  event ring accepted request.
CCS  output  1  debounced current connect status.
PLS  output  PLS_W  registered link state.
CSC  output  1  connect status change (sticky).
PLC  output  1  port link state change (sticky).
PRC  output  1  port reset change (sticky).
CEC  output  1  config error change (sticky).
PED  output  1  port enabled.
evt_req  output  1  port status change event request.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, debounce counter 0, debounce FSM in STABLE, event FSM in IDLE.
- DCE=0 is a synchronous clear. While low, every output and every FSM is held at its reset value. Inputs are ignored and w1c has no effect.
- Debounce FSM, states STABLE and COUNT:
  - STABLE: when sampled conn_raw != CCS, go to COUNT with counter=1.
  - COUNT: if conn_raw == CCS, go to STABLE with counter=0. Otherwise increment the counter.
  - On the edge where the counter reaches DEBOUNCE_CYCLES: CCS toggles, CSC sets, FSM returns to STABLE.
  - With DEBOUNCE_CYCLES=1, CCS follows conn_raw one edge after the change.
- PLS: registered from pls_in every cycle while DCE=1.
  - PLC sets on the edge where the new PLS value differs from the old one and CCS=1.
- PRC: sets on the edge after port_rst_busy is sampled 1 then 0 (falling edge).
  - On that same edge PED sets if CCS=1.
- PED clears on any of:
  - the edge CCS falls (this edge also sets CSC);
  - cfg_err=1;
  - port_rst_busy rising (PED is 0 during reset).
- CEC: sets on any cycle cfg_err=1.
- W1C: on w1c_valid, each masked change bit clears.
  - If a set event and a clear hit the same bit on the same edge, set wins.
  - Unmasked bits are unaffected.
- Event FSM, states IDLE, REQ and WAIT_CLR. Let any_chg = CSC|PLC|PRC|CEC, using registered values.
  - IDLE: if any_chg, go to REQ; evt_req=1 from the next cycle.
  - REQ: evt_req held at 1 until evt_ack is sampled 1, then go to WAIT_CLR with evt_req=0.
  - WAIT_CLR: no new request until any_chg==0, then go to IDLE. Changes that arrive in WAIT_CLR are coalesced.
  - evt_ack outside REQ is ignored.
- Reset or DCE drop mid-request: evt_req deasserts immediately (reset) or on the next edge (DCE); no ack is expected afterwards.

Optional Feature:
DBC_PLS_LPM_FILTER_EN
- Defined: PLC is not set for transitions between U0 (0) and U1 (1), or between U0 and U2 (2), in either direction. All other PLS changes set PLC as normal. PLS itself still updates.
- Undefined: every PLS change while CCS=1 sets PLC.

Test Plan:
- Reset release, DCE=1, conn_raw=1 steady, DEBOUNCE_CYCLES=16 -> CCS and CSC rise on the 16th edge after conn_raw sampled 1; evt_req rises 1 cycle later.
- conn_raw glitch 1 for 5 cycles, then 0 -> CCS, CSC and evt_req stay 0.
- Connected; port_rst_busy 1 for 10 cycles, then 0 -> PRC=1 and PED=1 on the edge after the fall. Then cfg_err pulse -> CEC=1, PED=0.
- evt_req=1; ack; pls_in 0->5 during WAIT_CLR -> PLC=1 but no new evt_req. w1c_mask=4'b1111 -> bits cleared, FSM to IDLE. Next change -> new evt_req.
- w1c clearing CSC on the same edge CCS toggles -> CSC stays 1.
- DCE dropped during REQ -> all outputs 0 next edge. With filter defined, pls_in 0->1->0 -> PLC stays 0; 0->3 -> PLC=1.
